simple_router: RTL and testbench
================================

Name: simple_router

Overview:
- 1-to-4 demultiplexing router: a data word on din is steered to one of four output ports selected by a 2-bit addr.
- Transfer is qualified by din_en.
- All outputs are registered: one clock of latency, all outputs zero when idle.
- Sits between a single producer and four downstream consumers; no backpressure.

Parameters:
DATA_WIDTH, 32, width of din and each doutN (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
din  input  DATA_WIDTH  data word to route
din_en  input  1  qualifies din/addr for the current cycle
addr  input  2  destination port select (0..3)
dout0  output  DATA_WIDTH  port 0 data; zero when not selected
dout1  output  DATA_WIDTH  port 1 data; zero when not selected
dout2  output  DATA_WIDTH  port 2 data; zero when not selected
dout3  output  DATA_WIDTH  port 3 data; zero when not selected
dout_vld  output  4  bit N high when doutN carries routed data this cycle

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - While reset is high, all dout0..dout3 = 0 and dout_vld = 4'b0000, regardless of clk.
  - Deassertion takes effect at the next rising clk edge.
- Each rising clk edge with reset low:
  - If din_en=1: the port selected by addr loads din, and dout_vld[addr] goes to 1. The other three ports load 0 and their dout_vld bits go to 0.
  - If din_en=0: all four ports load 0 and dout_vld = 0.
- Latency: exactly 1 cycle from input sample to output. Outputs are stable for the whole cycle. No combinational path from inputs to outputs.
- One-hot invariant: at most one dout_vld bit is set. An unselected port always reads exactly zero, never a stale value.
- Per-cycle routing: back-to-back transfers to different ports need no gap. Data on a port persists only while the same addr/din_en is re-presented each cycle.
- Changing din with addr held: the new value appears on the same port on the next edge.
- din value of 0 with din_en=1 is a valid transfer: dout is 0 and dout_vld is 1. Consumers must use dout_vld, not nonzero data.
- addr or din containing X/Z while din_en=0: outputs remain 0. Behaviour with X and din_en=1 is undefined.
- Reset asserted mid-stream: outputs clear immediately. The in-flight word is discarded.

Decomposition:
- Shared package simple_router_pkg:
  - DATA_WIDTH default constant (32)
  - NUM_PORTS = 4
  - port-index typedef (logic [1:0])
- One sub-module is natural: simple_router_port. It is a per-port output register with async reset.
  - Inputs: clk, reset, sel (addr==N && din_en), din.
  - Outputs: dout, vld.
  - Instantiated four times via generate.
- Top level holds only the address decode.

Test Plan:
- Reset: hold reset=1 with din=32'hA5A5A5A5, din_en=1, addr=0, and toggle clk -> all dout=0, dout_vld=0. Assert reset asynchronously mid-cycle with data on dout2 -> dout2 clears before the next edge.
- Enable gating: din=32'hA5A5A5A5, addr=0, din_en=0 for 2 edges -> all dout=0, dout_vld=0.
- Port sweep: din_en=1, din=32'hA5A5A5A5, addr 0,1,2,3 on successive edges -> one cycle later only the addressed port = A5A5A5A5, others 0, dout_vld = 0001, 0010, 0100, 1000.
- Data change on held address: addr=3, din changes A5A5A5A5 -> 5A5A5A5A -> next edge dout3=5A5A5A5A, others 0, dout_vld=1000.
- Zero-data transfer and de-assert: din=0, din_en=1, addr=1 -> dout1=0 with dout_vld=0010. Then din_en=0 -> dout_vld=0 on the next edge.
- Random: 1000 cycles of random din/addr/din_en against a 1-cycle-delayed reference model -> exact match and one-hot dout_vld every cycle.

Source files
------------

// File: rtl/simple_router_pkg.sv
// -----------------------------------------------------------------------------
// simple_router_pkg
// Shared constants and types for the 1-to-4 demultiplexing router.
//   DEFAULT_DATA_WIDTH : default width of the routed data word
//   NUM_PORTS          : number of downstream output ports
//   port_idx_t         : destination port index (0..NUM_PORTS-1)
// -----------------------------------------------------------------------------
package simple_router_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned NUM_PORTS          = 4;

  typedef logic [1:0] port_idx_t;

endpackage : simple_router_pkg

// File: rtl/simple_router_port.sv
// -----------------------------------------------------------------------------
// simple_router_port
// One registered output port of the router. Loads din when selected,
// otherwise loads zero, so an unselected port never shows a stale word.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset (clears dout and vld)
//   sel   : this port is the destination of a qualified transfer this cycle
//   din   : data word to capture when selected
//   dout  : registered port data, zero when not selected
//   vld   : registered flag, high when dout carries routed data
// -----------------------------------------------------------------------------
module simple_router_port
  import simple_router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  vld
);

  // Data and valid are reloaded every cycle; a word only persists while the
  // producer keeps re-presenting it to this port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
      vld  <= 1'b0;
    end else begin
      dout <= sel ? din : '0;
      vld  <= sel;
    end
  end

endmodule : simple_router_port

// File: rtl/simple_router.sv
// -----------------------------------------------------------------------------
// simple_router
// 1-to-4 demultiplexing router with one cycle of registered latency and no
// backpressure. The top level only decodes addr/din_en into per-port selects;
// each port owns its output register.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous, active-high reset
//   din      : data word to route
//   din_en   : qualifies din/addr for the current cycle
//   addr     : destination port select (0..3)
//   dout0..3 : per-port data, zero when that port is not selected
//   dout_vld : bit N high when doutN carries routed data (at most one set)
// -----------------------------------------------------------------------------
module simple_router
  import simple_router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_en,
  input  port_idx_t             addr,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic [DATA_WIDTH-1:0] dout2,
  output logic [DATA_WIDTH-1:0] dout3,
  output logic [NUM_PORTS-1:0]  dout_vld
);

  logic [DATA_WIDTH-1:0] port_dout [NUM_PORTS];
  logic [NUM_PORTS-1:0]  port_sel;

  // din_en gates the decode first so an unknown addr while idle still yields
  // a clean all-zero select vector.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign port_sel[i] = din_en && (addr == port_idx_t'(i));

    simple_router_port #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_port (
      .clk   (clk),
      .reset (reset),
      .sel   (port_sel[i]),
      .din   (din),
      .dout  (port_dout[i]),
      .vld   (dout_vld[i])
    );
  end

  assign dout0 = port_dout[0];
  assign dout1 = port_dout[1];
  assign dout2 = port_dout[2];
  assign dout3 = port_dout[3];

endmodule : simple_router

// File: tb/tb_simple_router.sv
// -----------------------------------------------------------------------------
// tb_simple_router
// Self-checking bench for simple_router: directed steps followed by random
// traffic, compared against a per-port reference model of the routing rules.
// -----------------------------------------------------------------------------
module tb_simple_router;

  localparam int unsigned DW = 32;

  logic          clk;
  logic          reset;
  logic [DW-1:0] din;
  logic          din_en;
  logic [1:0]    addr;
  logic [DW-1:0] dout0, dout1, dout2, dout3;
  logic [3:0]    dout_vld;

  logic [DW-1:0] obs_dout [4];
  logic [DW-1:0] exp_dout [4];
  logic [3:0]    exp_vld;

  int vectors;
  int miscompares;

  simple_router #(
    .DATA_WIDTH (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .din_en   (din_en),
    .addr     (addr),
    .dout0    (dout0),
    .dout1    (dout1),
    .dout2    (dout2),
    .dout3    (dout3),
    .dout_vld (dout_vld)
  );

  assign obs_dout[0] = dout0;
  assign obs_dout[1] = dout1;
  assign obs_dout[2] = dout2;
  assign obs_dout[3] = dout3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: after an edge, only the addressed port holds din, everything
  // else is zero; an idle cycle or reset leaves all ports zero.
  task automatic modelClear();
    for (int p = 0; p < 4; p++) exp_dout[p] = '0;
    exp_vld = 4'b0000;
  endtask

  task automatic modelEdge(input logic en, input logic [1:0] a, input logic [DW-1:0] d);
    modelClear();
    if (en === 1'b1) begin
      exp_dout[a] = d;
      exp_vld     = 4'b0001 << a;
    end
  endtask

  task automatic checkOutput(input string tag);
    for (int p = 0; p < 4; p++) begin
      vectors++;
      assert (obs_dout[p] === exp_dout[p])
      else begin
        miscompares++;
        $error("[TB] FAIL %s dout%0d: observed %h expected %h", tag, p, obs_dout[p], exp_dout[p]);
      end
    end
    vectors++;
    assert (dout_vld === exp_vld)
    else begin
      miscompares++;
      $error("[TB] FAIL %s dout_vld: observed %b expected %b", tag, dout_vld, exp_vld);
    end
    vectors++;
    assert ($countones(dout_vld) <= 1)
    else begin
      miscompares++;
      $error("[TB] FAIL %s onehot: observed %b expected at most one bit", tag, dout_vld);
    end
  endtask

  // Drive one cycle of input (called just after an edge), advance through the
  // next rising edge, update the model and check 1 time unit later.
  task automatic applyStimulus(input logic en, input logic [1:0] a, input logic [DW-1:0] d,
                               input string tag);
    din_en = en;
    addr   = a;
    din    = d;
    @(posedge clk);
    modelEdge(en, a, d);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset held while inputs request a transfer and the clock runs.
    reset  = 1'b1;
    din    = 32'hA5A5A5A5;
    din_en = 1'b1;
    addr   = 2'd0;
    modelClear();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hold");

    // Release reset away from the edge with the producer idle.
    din_en = 1'b0;
    reset  = 1'b0;
    applyStimulus(1'b0, 2'd0, 32'hA5A5A5A5, "en_gate0");
    applyStimulus(1'b0, 2'd0, 32'hA5A5A5A5, "en_gate1");

    // Port sweep with back-to-back transfers.
    applyStimulus(1'b1, 2'd0, 32'hA5A5A5A5, "sweep0");
    applyStimulus(1'b1, 2'd1, 32'hA5A5A5A5, "sweep1");
    applyStimulus(1'b1, 2'd2, 32'hA5A5A5A5, "sweep2");
    applyStimulus(1'b1, 2'd3, 32'hA5A5A5A5, "sweep3");

    // New data on a held address.
    applyStimulus(1'b1, 2'd3, 32'h5A5A5A5A, "held_addr");

    // Zero data is still a valid transfer, then the port drops.
    applyStimulus(1'b1, 2'd1, 32'h00000000, "zero_data");
    applyStimulus(1'b0, 2'd1, 32'h00000000, "deassert");

    // Unknown addr/din while idle must leave outputs clean.
    applyStimulus(1'b0, 2'bxx, {DW{1'bx}}, "x_idle");

    // Asynchronous reset mid-cycle with a word sitting on port 2.
    applyStimulus(1'b1, 2'd2, 32'hDEADBEEF, "pre_async");
    din_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    modelClear();
    checkOutput("async_reset");
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_async");

    // Random traffic.
    for (int n = 0; n < 1000; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), DW'($urandom), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_simple_router
